// File: rtl/mips8_pkg.sv
// Shared definitions for the 8-bit, 8-register MIPS core.
package mips8_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned REG_AW = 3;
    localparam int unsigned OP_W   = 3;

    // ALU operation codes carried through the pipeline untouched.
    localparam logic [OP_W-1:0] ALU_ADD = 3'd0;
    localparam logic [OP_W-1:0] ALU_SUB = 3'd1;
    localparam logic [OP_W-1:0] ALU_AND = 3'd2;
    localparam logic [OP_W-1:0] ALU_OR  = 3'd3;
    localparam logic [OP_W-1:0] ALU_SLT = 3'd4;
    localparam logic [OP_W-1:0] ALU_XOR = 3'd5;
    localparam logic [OP_W-1:0] ALU_NOR = 3'd6;
    localparam logic [OP_W-1:0] ALU_SLL = 3'd7;

    // Registered payload presented to the EX stage.
    typedef struct packed {
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
        logic [REG_AW-1:0] rd;
        logic [OP_W-1:0]   alu_op;
        logic              regwr;
    } ex_payload_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass selector: EX result beats WB write data beats register-file data.
module fwd_mux
    import mips8_pkg::*;
(
    input  logic [REG_AW-1:0] rs,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              ex_fwd_en,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              wb_regwr,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] operand
);

    // EX holds the younger result, so it is checked first.
    always_comb begin
        operand = rf_data;
        if (ex_fwd_en && (ex_rd == rs)) begin
            operand = ex_result;
        end else if (wb_regwr && (wb_rd == rs)) begin
            operand = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with RAW bypassing, valid/ready handshake, flush
// and a saturating stall counter.
module id_ex_stage
    import mips8_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_data1,
    input  logic [DATA_W-1:0] id_data2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [OP_W-1:0]   id_alu_op,
    input  logic              id_regwr,
    input  logic              id_use_imm,
    input  logic              wb_regwr,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              flush,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] ex_op_a,
    output logic [DATA_W-1:0] ex_op_b,
    output logic [REG_AW-1:0] ex_rd,
    output logic [OP_W-1:0]   ex_alu_op,
    output logic              ex_regwr,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              ex_valid_q;
    ex_payload_t       pay_q;
    ex_payload_t       pay_d;
    logic [CNT_W-1:0]  stall_q;
    logic              capture;
    logic              stalled;
    logic              ex_fwd_en;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    assign id_ready  = !ex_valid_q || ex_ready;
    assign capture   = id_valid && id_ready && !flush;
    assign stalled   = id_valid && !id_ready && !flush;
    // Only a live instruction that writes rd may bypass its result.
    assign ex_fwd_en = ex_valid_q && pay_q.regwr;

    fwd_mux u_fwd_a (
        .rs        (id_rs1),
        .rf_data   (id_data1),
        .ex_fwd_en (ex_fwd_en),
        .ex_rd     (pay_q.rd),
        .ex_result (ex_result),
        .wb_regwr  (wb_regwr),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .operand   (fwd_a)
    );

    fwd_mux u_fwd_b (
        .rs        (id_rs2),
        .rf_data   (id_data2),
        .ex_fwd_en (ex_fwd_en),
        .ex_rd     (pay_q.rd),
        .ex_result (ex_result),
        .wb_regwr  (wb_regwr),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .operand   (fwd_b)
    );

    // Assemble the payload that would be captured this cycle.
    always_comb begin
        pay_d        = '0;
        pay_d.op_a   = fwd_a;
        pay_d.op_b   = id_use_imm ? id_imm : fwd_b;
        pay_d.rd     = id_rd;
        pay_d.alu_op = id_alu_op;
        pay_d.regwr  = id_regwr;
    end

    // Handshake and payload: flush kills both the held and incoming instruction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_valid_q <= 1'b0;
            pay_q      <= '0;
        end else if (flush) begin
            ex_valid_q <= 1'b0;
        end else if (capture) begin
            ex_valid_q <= 1'b1;
            pay_q      <= pay_d;
        end else if (ex_ready) begin
            ex_valid_q <= 1'b0;
        end
    end

    // Saturating count of cycles where decode was held off.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (stalled && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign ex_op_a   = pay_q.op_a;
    assign ex_op_b   = pay_q.op_b;
    assign ex_rd     = pay_q.rd;
    assign ex_alu_op = pay_q.alu_op;
    assign ex_regwr  = pay_q.regwr;
    assign stall_cnt = stall_q;

`ifndef SYNTHESIS
    // A held, unconsumed instruction must not change under the consumer.
    hold_stable : assert property (@(posedge clk) disable iff (!reset)
        (ex_valid_q && !ex_ready) |=> $stable(pay_q));
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table, directed corner cases,
// then randomized traffic against a behavioural model.
module tb_id_ex_stage;
    import mips8_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       id_valid = 1'b0;
    logic       id_ready;
    logic [2:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic [7:0] id_data1 = '0, id_data2 = '0, id_imm = '0;
    logic [2:0] id_alu_op = '0;
    logic       id_regwr = 1'b0, id_use_imm = 1'b0;
    logic       wb_regwr = 1'b0;
    logic [2:0] wb_rd = '0;
    logic [7:0] wb_data = '0, ex_result = '0;
    logic       flush = 1'b0;
    logic       ex_valid;
    logic       ex_ready = 1'b0;
    logic [7:0] ex_op_a, ex_op_b;
    logic [2:0] ex_rd, ex_alu_op;
    logic       ex_regwr;
    logic [7:0] stall_cnt;

    id_ex_stage #(.CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rd      (id_rd),
        .id_data1   (id_data1),
        .id_data2   (id_data2),
        .id_imm     (id_imm),
        .id_alu_op  (id_alu_op),
        .id_regwr   (id_regwr),
        .id_use_imm (id_use_imm),
        .wb_regwr   (wb_regwr),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .ex_result  (ex_result),
        .flush      (flush),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_op_a    (ex_op_a),
        .ex_op_b    (ex_op_b),
        .ex_rd      (ex_rd),
        .ex_alu_op  (ex_alu_op),
        .ex_regwr   (ex_regwr),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] a,
                           input logic [7:0] b, input logic [2:0] rd, input logic [2:0] op,
                           input logic rw);
        chk({tag, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, v});
        chk({tag, ".op_a"}, {24'd0, ex_op_a}, {24'd0, a});
        chk({tag, ".op_b"}, {24'd0, ex_op_b}, {24'd0, b});
        chk({tag, ".rd"}, {29'd0, ex_rd}, {29'd0, rd});
        chk({tag, ".alu_op"}, {29'd0, ex_alu_op}, {29'd0, op});
        chk({tag, ".regwr"}, {31'd0, ex_regwr}, {31'd0, rw});
    endtask

    task automatic set_instr(input logic v, input logic [2:0] rs1, input logic [2:0] rs2,
                             input logic [2:0] rd, input logic [7:0] d1, input logic [7:0] d2);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_data1 = d1; id_data2 = d2;
    endtask

    typedef struct {
        logic       vld;
        logic [2:0] rs1, rs2, rd;
        logic [7:0] d1, d2, imm;
        logic [2:0] op;
        logic       regwr, use_imm, wbw;
        logic [2:0] wbrd;
        logic [7:0] wbd, exr;
        logic       rdy;
        logic       e_idrdy, e_valid;
        logic [7:0] e_a, e_b;
        logic [2:0] e_rd, e_op;
        logic       e_regwr;
    } vec_t;

    vec_t vecs[7];

    // Behavioural model of the stage, kept as plain variables.
    logic       m_valid;
    logic [7:0] m_a, m_b;
    logic [2:0] m_rd, m_op;
    logic       m_regwr;
    int         m_cnt;

    function automatic logic [7:0] src_val(input logic [2:0] rs, input logic [7:0] rf);
        if (m_valid && m_regwr && m_rd == rs) return ex_result;
        if (wb_regwr && wb_rd == rs) return wb_data;
        return rf;
    endfunction

    initial begin
        // Vector rows run back to back from reset; each row depends on the one before.
        vecs[0] = '{1'b1, 3'd2, 3'd3, 3'd2, 8'h22, 8'h33, 8'h00, ALU_ADD, 1'b1, 1'b0, 1'b0, 3'd0,
                    8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 8'h33, 3'd2, ALU_ADD, 1'b1};
        vecs[1] = '{1'b1, 3'd2, 3'd5, 3'd3, 8'h01, 8'h55, 8'h00, ALU_SUB, 1'b1, 1'b0, 1'b1, 3'd2,
                    8'h11, 8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, 8'h55, 3'd3, ALU_SUB, 1'b1};
        vecs[2] = '{1'b1, 3'd4, 3'd3, 3'd6, 8'h04, 8'h99, 8'hF0, ALU_SLT, 1'b0, 1'b1, 1'b1, 3'd4,
                    8'h7F, 8'hAA, 1'b1, 1'b1, 1'b1, 8'h7F, 8'hF0, 3'd6, ALU_SLT, 1'b0};
        vecs[3] = '{1'b1, 3'd6, 3'd6, 3'd0, 8'h01, 8'h02, 8'h00, ALU_AND, 1'b1, 1'b0, 1'b1, 3'd6,
                    8'h66, 8'hEE, 1'b1, 1'b1, 1'b1, 8'h66, 8'h66, 3'd0, ALU_AND, 1'b1};
        vecs[4] = '{1'b1, 3'd0, 3'd7, 3'd1, 8'h10, 8'h70, 8'h00, ALU_OR, 1'b0, 1'b0, 1'b1, 3'd7,
                    8'h77, 8'hC3, 1'b1, 1'b1, 1'b1, 8'hC3, 8'h77, 3'd1, ALU_OR, 1'b0};
        vecs[5] = '{1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, ALU_ADD, 1'b0, 1'b0, 1'b0, 3'd0,
                    8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'hC3, 8'h77, 3'd1, ALU_OR, 1'b0};
        vecs[6] = '{1'b1, 3'd1, 3'd1, 3'd5, 8'hA1, 8'hB2, 8'h0C, ALU_XOR, 1'b1, 1'b1, 1'b0, 3'd0,
                    8'h00, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hA1, 8'h0C, 3'd5, ALU_XOR, 1'b1};

        // Reset held for two clocks with a valid instruction offered.
        reset = 1'b0;
        set_instr(1'b1, 3'd1, 3'd2, 3'd3, 8'hAB, 8'hCD);
        id_regwr = 1'b1; ex_ready = 1'b0;
        tick();
        tick();
        chk_out("reset", 1'b0, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0);
        chk("reset.stall_cnt", {24'd0, stall_cnt}, 32'd0);
        reset = 1'b1;
        id_valid = 1'b0;
        #1;
        chk("reset.id_ready", {31'd0, id_ready}, 32'd1);

        for (int i = 0; i < 7; i++) begin
            set_instr(vecs[i].vld, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].d1, vecs[i].d2);
            id_imm = vecs[i].imm; id_alu_op = vecs[i].op; id_regwr = vecs[i].regwr;
            id_use_imm = vecs[i].use_imm; wb_regwr = vecs[i].wbw; wb_rd = vecs[i].wbrd;
            wb_data = vecs[i].wbd; ex_result = vecs[i].exr; ex_ready = vecs[i].rdy;
            flush = 1'b0;
            #1;
            chk($sformatf("vec%0d.id_ready", i), {31'd0, id_ready}, {31'd0, vecs[i].e_idrdy});
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_a, vecs[i].e_b,
                    vecs[i].e_rd, vecs[i].e_op, vecs[i].e_regwr);
        end

        // Stall: consumer busy for three cycles while decode keeps offering.
        wb_regwr = 1'b0; id_use_imm = 1'b0;
        set_instr(1'b1, 3'd3, 3'd3, 3'd4, 8'h5A, 8'h5B);
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall.id_ready", {31'd0, id_ready}, 32'd0);
            tick();
            chk_out("stall", 1'b1, 8'hA1, 8'h0C, 3'd5, ALU_XOR, 1'b1);
        end
        chk("stall.stall_cnt", {24'd0, stall_cnt}, 32'd3);
        set_instr(1'b1, 3'd1, 3'd4, 3'd7, 8'h3C, 8'h44);
        id_alu_op = ALU_NOR; id_regwr = 1'b0;
        ex_ready = 1'b1;
        #1;
        chk("release.id_ready", {31'd0, id_ready}, 32'd1);
        tick();
        chk_out("release", 1'b1, 8'h3C, 8'h44, 3'd7, ALU_NOR, 1'b0);
        chk("release.stall_cnt", {24'd0, stall_cnt}, 32'd3);

        // Flush colliding with an accepted capture.
        set_instr(1'b1, 3'd2, 3'd2, 3'd2, 8'h12, 8'h34);
        flush = 1'b1;
        tick();
        chk("flush.ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush.op_a_hold", {24'd0, ex_op_a}, 32'h3C);
        flush = 1'b0;
        tick();
        chk("recap.ex_valid", {31'd0, ex_valid}, 32'd1);
        // Flush while stalled: no stall counted, held instruction dropped.
        ex_ready = 1'b0; flush = 1'b1;
        tick();
        chk("flushstall.ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("flushstall.stall_cnt", {24'd0, stall_cnt}, 32'd3);
        flush = 1'b0;
        tick();
        // Long stall saturates the counter.
        for (int i = 0; i < 300; i++) tick();
        chk("sat.stall_cnt", {24'd0, stall_cnt}, 32'd255);
        tick();
        chk("sat_hold.stall_cnt", {24'd0, stall_cnt}, 32'd255);
        chk("sat.ex_valid", {31'd0, ex_valid}, 32'd1);

        // Reset mid-stall drops everything.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        id_valid = 1'b0;
        #1;
        chk("midrst.ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("midrst.stall_cnt", {24'd0, stall_cnt}, 32'd0);
        chk("midrst.op_a", {24'd0, ex_op_a}, 32'd0);
        chk("midrst.id_ready", {31'd0, id_ready}, 32'd1);

        // Randomized traffic against the model, starting from reset state.
        m_valid = 1'b0; m_a = '0; m_b = '0; m_rd = '0; m_op = '0; m_regwr = 1'b0; m_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            logic       n_valid, take, rdy;
            logic [7:0] n_a, n_b;
            id_valid   = ($urandom % 4) != 0;
            id_rs1     = 3'($urandom); id_rs2 = 3'($urandom); id_rd = 3'($urandom);
            id_data1   = 8'($urandom); id_data2 = 8'($urandom); id_imm = 8'($urandom);
            id_alu_op  = 3'($urandom); id_regwr = 1'($urandom); id_use_imm = 1'($urandom);
            wb_regwr   = 1'($urandom); wb_rd = 3'($urandom); wb_data = 8'($urandom);
            ex_result  = 8'($urandom);
            ex_ready   = ($urandom % 3) != 0;
            flush      = ($urandom % 10) == 0;
            #1;
            rdy = !m_valid || ex_ready;
            chk("rand.id_ready", {31'd0, id_ready}, {31'd0, rdy});
            take = id_valid && rdy && !flush;
            n_a = src_val(id_rs1, id_data1);
            n_b = id_use_imm ? id_imm : src_val(id_rs2, id_data2);
            if (flush) n_valid = 1'b0;
            else if (take) n_valid = 1'b1;
            else if (ex_ready) n_valid = 1'b0;
            else n_valid = m_valid;
            if (id_valid && !rdy && !flush && m_cnt < 255) m_cnt++;
            if (take) begin
                m_a = n_a; m_b = n_b; m_rd = id_rd; m_op = id_alu_op; m_regwr = id_regwr;
            end
            m_valid = n_valid;
            tick();
            chk_out("rand", m_valid, m_a, m_b, m_rd, m_op, m_regwr);
            chk("rand.stall_cnt", {24'd0, stall_cnt}, 32'(m_cnt));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
